status_register_ctrl: RTL

STATUS_REGISTER_CTRL -- requirements
Module: status_register_ctrl

---
 rtl/status_pkg.sv | 18 +
 rtl/status_channel.sv | 80 ++++++++
 rtl/status_register_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/status_pkg.sv
// Shared constants for the SPI status register block: per-channel bit layout
// and the reset/sticky/live masks used by the channel and top-level logic.
package status_pkg;

    localparam int BIT_SENDER_FULL    = 0;
    localparam int BIT_RECEIVER_EMPTY = 1;
    localparam int BIT_RECEIVER_FULL  = 2;
    localparam int BIT_TX_OVF         = 3;
    localparam int BIT_SENDER_EMPTY   = 4;
    localparam int BIT_TX_DONE        = 5;
    localparam int BIT_RX_UNF         = 6;
    localparam int BIT_CONN_FAIL      = 7;

    localparam logic [7:0] STATUS_RST  = 8'h12;
    localparam logic [7:0] STICKY_MASK = 8'hE8;
    localparam logic [7:0] LIVE_MASK   = 8'h17;

endpackage

// File: rtl/status_channel.sv
// One channel's status register: registered live FIFO flags, sticky error/event
// bits with set-over-clear priority, and a saturating connection watchdog.
module status_channel
    import status_pkg::*;
#(
    parameter int TO_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_sender_full,
    input  logic            i_sender_empty,
    input  logic            i_receiver_full,
    input  logic            i_receiver_empty,
    input  logic            i_sender_write,
    input  logic            i_receiver_read,
    input  logic            i_byte_done,
    input  logic [TO_W-1:0] i_timeout_limit,
    input  logic            i_clr_en,
    input  logic [7:0]      i_clr_mask,
    output logic [7:0]      o_status
);

    logic [7:0]      r_status;
    logic [TO_W-1:0] r_wdog_cnt;

    logic [7:0]      w_set;
    logic [7:0]      w_clr;
    logic [7:0]      w_live;
    logic [7:0]      w_sticky_nxt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            w_wdog_hit;

    // Next sticky/live contents and watchdog count; set events override clears.
    always_comb begin
        w_wdog_hit = (i_timeout_limit != '0) && (r_wdog_cnt >= i_timeout_limit);

        w_set = 8'h00;
        w_set[BIT_TX_OVF]    = i_sender_write & i_sender_full;
        w_set[BIT_TX_DONE]   = i_sender_empty & ~r_status[BIT_SENDER_EMPTY];
        w_set[BIT_RX_UNF]    = i_receiver_read & i_receiver_empty;
        w_set[BIT_CONN_FAIL] = w_wdog_hit;

        w_live = 8'h00;
        w_live[BIT_SENDER_FULL]    = i_sender_full;
        w_live[BIT_RECEIVER_EMPTY] = i_receiver_empty;
        w_live[BIT_RECEIVER_FULL]  = i_receiver_full;
        w_live[BIT_SENDER_EMPTY]   = i_sender_empty;

        if (i_clr_en) begin
            w_clr = i_clr_mask & STICKY_MASK;
        end else begin
            w_clr = 8'h00;
        end

        w_sticky_nxt = ((r_status & ~w_clr) | w_set) & STICKY_MASK;

        // Counter holds at the limit rather than wrapping, so a lowered limit also clamps it.
        if (i_byte_done || i_sender_empty) begin
            w_cnt_nxt = '0;
        end else if (r_wdog_cnt >= i_timeout_limit) begin
            w_cnt_nxt = i_timeout_limit;
        end else begin
            w_cnt_nxt = r_wdog_cnt + TO_W'(1'b1);
        end
    end

    // Status register and watchdog counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_status   <= STATUS_RST;
            r_wdog_cnt <= '0;
        end else begin
            r_status   <= w_sticky_nxt | (w_live & LIVE_MASK);
            r_wdog_cnt <= w_cnt_nxt;
        end
    end

    assign o_status = r_status;

endmodule

// File: rtl/status_register_ctrl.sv
// Multi-channel SPI status register: per-channel status_channel instances plus
// the shared read mux, write-1-to-clear decode, IRQ mask and interrupt output.
module status_register_ctrl
    import status_pkg::*;
#(
    parameter  int N_CH = 2,
    parameter  int TO_W = 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            S_CLK,
    input  logic            CLR_N,
    input  logic [N_CH-1:0] SENDER_FULL,
    input  logic [N_CH-1:0] SENDER_EMPTY,
    input  logic [N_CH-1:0] RECEIVER_FULL,
    input  logic [N_CH-1:0] RECEIVER_EMPTY,
    input  logic [N_CH-1:0] SENDER_WRITE,
    input  logic [N_CH-1:0] RECEIVER_READ,
    input  logic [N_CH-1:0] BYTE_DONE,
    input  logic [TO_W-1:0] TIMEOUT_LIMIT,
    input  logic [CH_W-1:0] CH_SEL,
    input  logic            RD_STB,
    input  logic            CLR_STB,
    input  logic [7:0]      CLR_MASK,
    input  logic            MASK_WE,
    input  logic [7:0]      MASK_DATA,
    output logic [7:0]      STATUS_OUT,
    output logic            STATUS_VALID,
    output logic            IRQ
);

    logic [7:0]      w_ch_status [N_CH];
    logic [N_CH-1:0] w_clr_en;
    logic [7:0]      w_rd_data;
    logic            w_irq_any;

    logic [7:0]      r_status_out;
    logic            r_status_valid;
    logic [7:0]      r_irq_mask;
    logic            r_irq;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        status_channel #(
            .TO_W (TO_W)
        ) u_channel (
            .i_clk            (S_CLK),
            .i_rst_n          (CLR_N),
            .i_sender_full    (SENDER_FULL[g]),
            .i_sender_empty   (SENDER_EMPTY[g]),
            .i_receiver_full  (RECEIVER_FULL[g]),
            .i_receiver_empty (RECEIVER_EMPTY[g]),
            .i_sender_write   (SENDER_WRITE[g]),
            .i_receiver_read  (RECEIVER_READ[g]),
            .i_byte_done      (BYTE_DONE[g]),
            .i_timeout_limit  (TIMEOUT_LIMIT),
            .i_clr_en         (w_clr_en[g]),
            .i_clr_mask       (CLR_MASK),
            .o_status         (w_ch_status[g])
        );
    end

    // Channel decode for read/clear; unmatched selects read as zero and clear nothing.
    always_comb begin
        w_rd_data = 8'h00;
        w_clr_en  = '0;
        w_irq_any = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_SEL == CH_W'(i)) begin
                w_rd_data   = w_ch_status[i];
                w_clr_en[i] = CLR_STB;
            end else begin
                w_clr_en[i] = 1'b0;
            end
            w_irq_any = w_irq_any | (|(w_ch_status[i] & STICKY_MASK & r_irq_mask));
        end
    end

    // Read data capture, mask register and registered interrupt.
    always_ff @(posedge S_CLK) begin
        if (!CLR_N) begin
            r_status_out   <= 8'h00;
            r_status_valid <= 1'b0;
            r_irq_mask     <= 8'h00;
            r_irq          <= 1'b0;
        end else begin
            r_status_valid <= RD_STB;
            if (RD_STB) begin
                r_status_out <= w_rd_data;
            end
            if (MASK_WE) begin
                r_irq_mask <= MASK_DATA;
            end
            r_irq <= w_irq_any;
        end
    end

    assign STATUS_OUT   = r_status_out;
    assign STATUS_VALID = r_status_valid;
    assign IRQ          = r_irq;

endmodule
